// File: rtl/canvas_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | canvas_pkg                                                          |
// | Shared canvas defaults, FSM state encoding and colour helper.       |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package canvas_pkg;

   localparam int          FB_W_DEF        = 320;
   localparam int          FB_H_DEF        = 240;
   localparam logic [11:0] CLEAR_COLOR_DEF = 12'hFFF;
   localparam int          COLOR_MAX_W     = 48;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_STAMP = 2'd2
   } state_t;

   // Each set enable expands to an all-ones field; result packed as {R,G,B}.
   function automatic logic [COLOR_MAX_W-1:0] rgb_to_color(input logic [2:0] sel,
                                                          input int         field_w);
      logic [COLOR_MAX_W-1:0] mask;
      logic [COLOR_MAX_W-1:0] c;
      mask = (COLOR_MAX_W'(1) << field_w) - COLOR_MAX_W'(1);
      c    = ({COLOR_MAX_W{sel[0]}} & mask)
           | (({COLOR_MAX_W{sel[1]}} & mask) << field_w)
           | (({COLOR_MAX_W{sel[2]}} & mask) << (2 * field_w));
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/brush_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | brush_scanner                                                       |
// | Walks dy=-s..+s / dx=-s..+s around a latched centre, one per cycle. |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module brush_scanner
   import canvas_pkg::*;
#(
   parameter int FB_W    = FB_W_DEF,
   parameter int FB_H    = FB_H_DEF,
   parameter int SIZE_W  = 3,
   parameter int IN_W    = 10,
   parameter int COORD_W = 12
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [SIZE_W-1:0]         s,
   input  logic [IN_W-1:0]           cx,
   input  logic [IN_W-1:0]           cy,
   output logic signed [COORD_W-1:0] x,
   output logic signed [COORD_W-1:0] y,
   output logic                      in_range,
   output logic                      last
);

   localparam int OFS_W = SIZE_W + 1;
   localparam logic signed [OFS_W-1:0]   ONE    = OFS_W'(1);
   localparam logic signed [COORD_W-1:0] ZERO_C = '0;
   localparam logic signed [COORD_W-1:0] FB_W_C = COORD_W'(FB_W);
   localparam logic signed [COORD_W-1:0] FB_H_C = COORD_W'(FB_H);

   logic signed [OFS_W-1:0] dx_q, dx_d, dy_q, dy_d, s_q, s_d;
   logic [IN_W-1:0]         cx_q, cx_d, cy_q, cy_d;
   logic signed [OFS_W-1:0] s_ext;
   logic signed [COORD_W-1:0] cx_ext, cy_ext, dx_ext, dy_ext;

   assign s_ext  = {1'b0, s};
   assign cx_ext = COORD_W'({1'b0, cx_q});
   assign cy_ext = COORD_W'({1'b0, cy_q});
   assign dx_ext = COORD_W'(dx_q);
   assign dy_ext = COORD_W'(dy_q);

   assign x        = cx_ext + dx_ext;
   assign y        = cy_ext + dy_ext;
   assign in_range = (x >= ZERO_C) && (x < FB_W_C) && (y >= ZERO_C) && (y < FB_H_C);
   assign last     = (dx_q == s_q) && (dy_q == s_q);

   always_comb begin
      dx_d = dx_q;
      dy_d = dy_q;
      s_d  = s_q;
      cx_d = cx_q;
      cy_d = cy_q;
      if (start) begin
         dx_d = -s_ext;
         dy_d = -s_ext;
         s_d  = s_ext;
         cx_d = cx;
         cy_d = cy;
      end else if (!last) begin
         // Holding at the final offset keeps dy from overflowing past +s.
         if (dx_q == s_q) begin
            dx_d = -s_q;
            dy_d = dy_q + ONE;
         end else begin
            dx_d = dx_q + ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dx_q <= '0;
         dy_q <= '0;
         s_q  <= '0;
         cx_q <= '0;
         cy_q <= '0;
      end else begin
         dx_q <= dx_d;
         dy_q <= dy_d;
         s_q  <= s_d;
         cx_q <= cx_d;
         cy_q <= cy_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/canvas_paint_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | canvas_paint_engine                                                 |
// | Canvas BRAM write engine: clear sweeps and square brush stamps.     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module canvas_paint_engine
   import canvas_pkg::*;
#(
   parameter int                 FB_W        = FB_W_DEF,
   parameter int                 FB_H        = FB_H_DEF,
   parameter int                 SCALE_SHIFT = 1,
   parameter int                 ADDR_W      = 17,
   parameter int                 COLOR_W     = 12,
   parameter int                 SIZE_W      = 3,
   parameter logic [COLOR_W-1:0] CLEAR_COLOR = CLEAR_COLOR_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear_req,
   input  logic [9:0]         mouse_x,
   input  logic [9:0]         mouse_y,
   input  logic               paint_btn,
   input  logic               erase_btn,
   input  logic [2:0]         color_sel,
   input  logic [SIZE_W-1:0]  brush_size,
   output logic               busy,
   output logic               we,
   output logic [ADDR_W-1:0]  addr,
   output logic [COLOR_W-1:0] wdata,
   output logic               clear_done
);

   localparam int               COORD_W   = 12;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    clr_addr_q, clr_addr_d;
   logic [COLOR_W-1:0]   color_q, color_d;
   logic                 held_q, held_d;
   logic [9:0]           last_fx_q, last_fx_d, last_fy_q, last_fy_d;
   logic [COLOR_W-1:0]   last_col_q, last_col_d;
   logic [SIZE_W-1:0]    last_size_q, last_size_d;
   logic                 we_q, we_d, clear_done_q, clear_done_d, busy_q, busy_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [COLOR_W-1:0]   wdata_q, wdata_d;

   logic [9:0]           fx, fy;
   logic                 btn, cursor_ok, is_new, scan_start;
   logic [COLOR_W-1:0]   sel_color;
   logic signed [COORD_W-1:0] scan_x, scan_y;
   logic                 scan_in_range, scan_last;
   logic [ADDR_W-1:0]    stamp_addr;

   assign fx        = mouse_x >> SCALE_SHIFT;
   assign fy        = mouse_y >> SCALE_SHIFT;
   assign btn       = paint_btn | erase_btn;
   assign cursor_ok = ({1'b0, fx} < 11'(FB_W)) && ({1'b0, fy} < 11'(FB_H));
   assign sel_color = erase_btn ? CLEAR_COLOR : COLOR_W'(rgb_to_color(color_sel, COLOR_W / 3));
   assign is_new    = !held_q || (fx != last_fx_q) || (fy != last_fy_q)
                    || (sel_color != last_col_q) || (brush_size != last_size_q);

   assign stamp_addr = ADDR_W'(ADDR_W'($unsigned(scan_y)) * FB_W) + ADDR_W'($unsigned(scan_x));

   brush_scanner #(
      .FB_W    (FB_W),
      .FB_H    (FB_H),
      .SIZE_W  (SIZE_W),
      .IN_W    (10),
      .COORD_W (COORD_W)
   ) u_scanner (
      .clk      (clk),
      .rst      (rst),
      .start    (scan_start),
      .s        (brush_size),
      .cx       (fx),
      .cy       (fy),
      .x        (scan_x),
      .y        (scan_y),
      .in_range (scan_in_range),
      .last     (scan_last)
   );

   always_comb begin
      state_d      = state_q;
      clr_addr_d   = clr_addr_q;
      color_d      = color_q;
      held_d       = held_q & btn;
      last_fx_d    = last_fx_q;
      last_fy_d    = last_fy_q;
      last_col_d   = last_col_q;
      last_size_d  = last_size_q;
      we_d         = 1'b0;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      clear_done_d = 1'b0;
      // busy tracks the state that produced the write now on the outputs.
      busy_d       = (state_q != ST_IDLE);
      scan_start   = 1'b0;

      case (state_q)
         ST_CLEAR: begin
            we_d    = 1'b1;
            addr_d  = clr_addr_q;
            wdata_d = CLEAR_COLOR;
            if (clr_addr_q == LAST_ADDR) begin
               clear_done_d = 1'b1;
               clr_addr_d   = '0;
               state_d      = ST_IDLE;
            end else begin
               clr_addr_d = clr_addr_q + 1'b1;
            end
         end
         ST_IDLE: begin
            if (clear_req) begin
               clr_addr_d = '0;
               state_d    = ST_CLEAR;
            end else if (btn && cursor_ok && is_new) begin
               scan_start  = 1'b1;
               color_d     = sel_color;
               held_d      = 1'b1;
               last_fx_d   = fx;
               last_fy_d   = fy;
               last_col_d  = sel_color;
               last_size_d = brush_size;
               state_d     = ST_STAMP;
            end
         end
         ST_STAMP: begin
            if (clear_req) begin
               clr_addr_d = '0;
               state_d    = ST_CLEAR;
            end else begin
               we_d    = scan_in_range;
               addr_d  = scan_in_range ? stamp_addr : addr_q;
               wdata_d = color_q;
               if (scan_last) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_CLEAR;
         clr_addr_q   <= '0;
         color_q      <= '0;
         held_q       <= 1'b0;
         last_fx_q    <= '0;
         last_fy_q    <= '0;
         last_col_q   <= '0;
         last_size_q  <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         clear_done_q <= 1'b0;
         busy_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         clr_addr_q   <= clr_addr_d;
         color_q      <= color_d;
         held_q       <= held_d;
         last_fx_q    <= last_fx_d;
         last_fy_q    <= last_fy_d;
         last_col_q   <= last_col_d;
         last_size_q  <= last_size_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         clear_done_q <= clear_done_d;
         busy_q       <= busy_d;
      end
   end

   assign busy       = busy_q;
   assign we         = we_q;
   assign addr       = addr_q;
   assign wdata      = wdata_q;
   assign clear_done = clear_done_q;

endmodule
`default_nettype wire

// File: tb/tb_canvas_paint_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_canvas_paint_engine                                              |
// | Directed bench for canvas_paint_engine (reduced 320x120 canvas).    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_canvas_paint_engine;

   localparam int FB_W = 320;
   localparam int FB_H = 120;
   localparam int NPIX = FB_W * FB_H;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear_req = 1'b0;
   logic [9:0]  mouse_x = '0;
   logic [9:0]  mouse_y = '0;
   logic        paint_btn = 1'b0;
   logic        erase_btn = 1'b0;
   logic [2:0]  color_sel = '0;
   logic [2:0]  brush_size = '0;
   logic        busy, we, clear_done;
   logic [16:0] addr;
   logic [11:0] wdata;

   int checks = 0;
   int errors = 0;

   logic [16:0] cap_addr[$];
   logic [11:0] cap_data[$];
   int          cap_busy, cap_busy_idle;

   always #5 clk = ~clk;

   canvas_paint_engine #(
      .FB_W (FB_W),
      .FB_H (FB_H)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clear_req  (clear_req),
      .mouse_x    (mouse_x),
      .mouse_y    (mouse_y),
      .paint_btn  (paint_btn),
      .erase_btn  (erase_btn),
      .color_sel  (color_sel),
      .brush_size (brush_size),
      .busy       (busy),
      .we         (we),
      .addr       (addr),
      .wdata      (wdata),
      .clear_done (clear_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic capture(input int cycles);
      cap_addr.delete();
      cap_data.delete();
      cap_busy      = 0;
      cap_busy_idle = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (we === 1'b1) begin
            cap_addr.push_back(addr);
            cap_data.push_back(wdata);
         end
         if (busy === 1'b1) begin
            cap_busy++;
            if (we !== 1'b1) cap_busy_idle++;
         end
      end
   endtask

   // Follows a clear sweep; optionally pulses clear_req after req_at cycles.
   task automatic collect_sweep(input int req_at, output int n, output int order_err,
                                output int done_cnt, output bit done_ok,
                                output bit busy_after, output bit timed_out);
      n = 0; order_err = 0; done_cnt = 0; done_ok = 1'b0; busy_after = 1'b1; timed_out = 1'b1;
      for (int i = 0; i < NPIX + 100; i++) begin
         tick();
         clear_req = (i == req_at);
         if (we === 1'b1) begin
            if (addr !== 17'(n) || wdata !== 12'hFFF) order_err++;
            n++;
         end else begin
            order_err++;
         end
         if (clear_done === 1'b1) begin
            done_cnt++;
            if (we === 1'b1 && addr === 17'(NPIX - 1)) done_ok = 1'b1;
            clear_req = 1'b0;
            tick();
            busy_after = busy;
            if (clear_done === 1'b1) done_cnt++;
            timed_out = 1'b0;
            break;
         end
      end
      clear_req = 1'b0;
   endtask

   task automatic check_sweep(input string tag, input int req_at);
      int n, oe, dc;
      bit dok, ba, to;
      collect_sweep(req_at, n, oe, dc, dok, ba, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL %s_timeout got %0d want 0", tag, to); end
      checks++; if (n !== NPIX) begin errors++; $display("FAIL %s_count got %0d want %0d", tag, n, NPIX); end
      checks++; if (oe !== 0) begin errors++; $display("FAIL %s_order got %0d bad cycles want 0", tag, oe); end
      checks++; if (dc !== 1) begin errors++; $display("FAIL %s_done_pulses got %0d want 1", tag, dc); end
      checks++; if (dok !== 1'b1) begin errors++; $display("FAIL %s_done_on_last got %0d want 1", tag, dok); end
      checks++; if (ba !== 1'b0) begin errors++; $display("FAIL %s_busy_after got %0d want 0", tag, ba); end
   endtask

   task automatic check_stamp(input string tag, input logic [16:0] exp_a[4], input logic [11:0] exp_d);
      logic [16:0] got;
      checks++;
      if (cap_addr.size() != 4) begin
         errors++; $display("FAIL %s_writes got %0d want 4", tag, cap_addr.size());
      end
      for (int k = 0; k < 4; k++) begin
         got = (k < cap_addr.size()) ? cap_addr[k] : 17'bx;
         checks++;
         if (got !== exp_a[k]) begin
            errors++; $display("FAIL %s_addr%0d got %0d want %0d", tag, k, got, exp_a[k]);
         end
         checks++;
         if (k >= cap_data.size() || cap_data[k] !== exp_d) begin
            errors++; $display("FAIL %s_data%0d got %h want %h", tag, k,
                               (k < cap_data.size()) ? cap_data[k] : 12'bx, exp_d);
         end
      end
      checks++; if (cap_busy !== 9) begin errors++; $display("FAIL %s_busy_cycles got %0d want 9", tag, cap_busy); end
      checks++; if (cap_busy_idle !== 5) begin errors++; $display("FAIL %s_idle_cycles got %0d want 5", tag, cap_busy_idle); end
   endtask

   task automatic stamp_pulse(input int mx, input int my, input int sz, input logic [2:0] sel,
                              input logic p, input logic e);
      mouse_x = 10'(mx); mouse_y = 10'(my); brush_size = 3'(sz); color_sel = sel;
      paint_btn = p; erase_btn = e;
      tick();
      paint_btn = 1'b0; erase_btn = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", we); end
      checks++; if (addr !== 17'd0) begin errors++; $display("FAIL rst_addr got %0d want 0", addr); end
      checks++; if (wdata !== 12'h000) begin errors++; $display("FAIL rst_wdata got %h want 000", wdata); end
      checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", clear_done); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", busy); end
      rst = 1'b0;
      check_sweep("boot", -1);
   endtask

   task automatic test_single_paint();
      stamp_pulse(100, 50, 0, 3'b100, 1'b1, 1'b0);
      capture(8);
      checks++; if (cap_addr.size() != 1) begin errors++; $display("FAIL single_writes got %0d want 1", cap_addr.size()); end
      checks++; if (cap_addr.size() < 1 || cap_addr[0] !== 17'd8050) begin errors++; $display("FAIL single_addr got %0d want 8050", (cap_addr.size() > 0) ? cap_addr[0] : 17'bx); end
      checks++; if (cap_data.size() < 1 || cap_data[0] !== 12'hF00) begin errors++; $display("FAIL single_data got %h want F00", (cap_data.size() > 0) ? cap_data[0] : 12'bx); end
      checks++; if (cap_busy !== 1) begin errors++; $display("FAIL single_busy got %0d want 1", cap_busy); end
   endtask

   task automatic test_corner();
      logic [16:0] ea[4];
      ea = '{17'd0, 17'd1, 17'd320, 17'd321};
      stamp_pulse(0, 0, 1, 3'b001, 1'b1, 1'b0);
      capture(14);
      check_stamp("corner", ea, 12'h00F);
   endtask

   task automatic test_far_edge();
      logic [16:0] ea[4];
      ea = '{17'd38078, 17'd38079, 17'd38398, 17'd38399};
      stamp_pulse(638, 238, 1, 3'b011, 1'b1, 1'b0);
      capture(14);
      check_stamp("far_edge", ea, 12'h0FF);
   endtask

   task automatic test_erase_and_range();
      stamp_pulse(200, 200, 0, 3'b010, 1'b1, 1'b1);
      capture(6);
      checks++; if (cap_addr.size() != 1) begin errors++; $display("FAIL erase_writes got %0d want 1", cap_addr.size()); end
      checks++; if (cap_addr.size() < 1 || cap_addr[0] !== 17'd32100) begin errors++; $display("FAIL erase_addr got %0d want 32100", (cap_addr.size() > 0) ? cap_addr[0] : 17'bx); end
      checks++; if (cap_data.size() < 1 || cap_data[0] !== 12'hFFF) begin errors++; $display("FAIL erase_data got %h want FFF", (cap_data.size() > 0) ? cap_data[0] : 12'bx); end
      mouse_x = 10'd640; mouse_y = 10'd10; paint_btn = 1'b1;
      capture(10);
      checks++; if (cap_addr.size() != 0) begin errors++; $display("FAIL oor_x_writes got %0d want 0", cap_addr.size()); end
      checks++; if (cap_busy !== 0) begin errors++; $display("FAIL oor_x_busy got %0d want 0", cap_busy); end
      mouse_x = 10'd10; mouse_y = 10'd240;
      capture(10);
      checks++; if (cap_addr.size() != 0) begin errors++; $display("FAIL oor_y_writes got %0d want 0", cap_addr.size()); end
      paint_btn = 1'b0;
      tick();
   endtask

   task automatic test_dedup();
      mouse_x = 10'd60; mouse_y = 10'd60; brush_size = 3'd0; color_sel = 3'b001; paint_btn = 1'b1;
      capture(100);
      checks++; if (cap_addr.size() != 1) begin errors++; $display("FAIL dedup_hold_writes got %0d want 1", cap_addr.size()); end
      checks++; if (cap_addr.size() < 1 || cap_addr[0] !== 17'd9630) begin errors++; $display("FAIL dedup_hold_addr got %0d want 9630", (cap_addr.size() > 0) ? cap_addr[0] : 17'bx); end
      mouse_x = 10'd61;
      capture(20);
      checks++; if (cap_addr.size() != 0) begin errors++; $display("FAIL dedup_same_fx got %0d want 0", cap_addr.size()); end
      mouse_x = 10'd62;
      capture(20);
      checks++; if (cap_addr.size() != 1 || cap_addr[0] !== 17'd9631) begin errors++; $display("FAIL dedup_move got %0d writes want 1 at 9631", cap_addr.size()); end
      color_sel = 3'b100;
      capture(20);
      checks++; if (cap_data.size() != 1 || cap_data[0] !== 12'hF00) begin errors++; $display("FAIL dedup_color got %0d writes want 1 of F00", cap_data.size()); end
      paint_btn = 1'b0;
      tick();
   endtask

   task automatic test_clear_abort();
      stamp_pulse(200, 200, 3, 3'b001, 1'b1, 1'b0);
      tick();
      checks++; if (we !== 1'b1 || addr !== 17'd31137) begin errors++; $display("FAIL abort_w1 got we=%b addr=%0d want 1/31137", we, addr); end
      tick();
      checks++; if (we !== 1'b1 || addr !== 17'd31138) begin errors++; $display("FAIL abort_w2 got we=%b addr=%0d want 1/31138", we, addr); end
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      checks++; if (we !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL abort_cut got we=%b busy=%b want 0/1", we, busy); end
      check_sweep("abort", 1000);
   endtask

   initial begin
      test_reset();
      test_single_paint();
      test_corner();
      test_far_edge();
      test_erase_and_range();
      test_dedup();
      test_clear_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
